// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM encoding and default flush length.
package hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_FLUSH     = 2'd1;
  localparam logic [1:0] ST_SYS_WAIT  = 2'd2;
  localparam logic [1:0] ST_MISS_WAIT = 2'd3;

  localparam int FLUSH_CYCLES_DEFAULT = 2;
  localparam int PERF_CNT_W           = 32;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: mispredict flush, syscall wait, icache-miss wait, load-use stall.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MISPREDICT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        SYSCALL,
  input  logic        SYSCALL_DONE,
  input  logic        ICACHE_MISS,
  input  logic        LOAD_USE,
  output logic        IFID_STALL,
  output logic        IFID_FLUSH,
  output logic        PC_STALL,
  output logic        PC_REDIRECT_VALID,
  output logic [31:0] PC_REDIRECT,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (MISPREDICT) begin
      state_nxt     = ST_FLUSH;
      flush_cnt_nxt = FLUSH_LOAD;
    end else begin
      case (state)
        ST_RUN: begin
          if (SYSCALL)          state_nxt = ST_SYS_WAIT;
          else if (ICACHE_MISS) state_nxt = ST_MISS_WAIT;
        end
        ST_FLUSH: begin
          if (flush_cnt == 3'd0) state_nxt = ICACHE_MISS ? ST_MISS_WAIT : ST_RUN;
          else                   flush_cnt_nxt = flush_cnt - 3'd1;
        end
        ST_SYS_WAIT: begin
          if (SYSCALL_DONE) state_nxt = ICACHE_MISS ? ST_MISS_WAIT : ST_RUN;
        end
        ST_MISS_WAIT: begin
          if (SYSCALL)           state_nxt = ST_SYS_WAIT;
          else if (!ICACHE_MISS) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state             <= ST_RUN;
      flush_cnt         <= 3'd0;
      PC_REDIRECT       <= 32'd0;
      PC_REDIRECT_VALID <= 1'b0;
    end else begin
      state             <= state_nxt;
      flush_cnt         <= flush_cnt_nxt;
      PC_REDIRECT_VALID <= MISPREDICT;
      if (MISPREDICT) PC_REDIRECT <= REDIRECT_PC;
    end
  end

  // Stall/flush are forced low during reset so a stale state cannot leak out.
  assign IFID_FLUSH = !RESET && (state == ST_FLUSH);
  assign IFID_STALL = !RESET && ((state == ST_SYS_WAIT) || (state == ST_MISS_WAIT) ||
                                 ((state == ST_RUN) && LOAD_USE && !MISPREDICT));
  assign PC_STALL   = IFID_STALL;

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .reset (RESET),
    .en    (IFID_STALL),
    .count (STALL_CNT)
  );

  sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .reset (RESET),
    .en    (IFID_FLUSH),
    .count (FLUSH_CNT)
  );
`else
  assign STALL_CNT = 32'd0;
  assign FLUSH_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each driven cycle pushes its expected outputs, sampled at negedge.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, MISPREDICT, SYSCALL, SYSCALL_DONE, ICACHE_MISS, LOAD_USE;
  logic [31:0] REDIRECT_PC;
  logic        IFID_STALL, IFID_FLUSH, PC_STALL, PC_REDIRECT_VALID;
  logic [31:0] PC_REDIRECT, STALL_CNT, FLUSH_CNT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        full;
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] pc;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] exp_sc = 32'd0;
  logic [31:0] exp_fc = 32'd0;

  hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .MISPREDICT        (MISPREDICT),
    .REDIRECT_PC       (REDIRECT_PC),
    .SYSCALL           (SYSCALL),
    .SYSCALL_DONE      (SYSCALL_DONE),
    .ICACHE_MISS       (ICACHE_MISS),
    .LOAD_USE          (LOAD_USE),
    .IFID_STALL        (IFID_STALL),
    .IFID_FLUSH        (IFID_FLUSH),
    .PC_STALL          (PC_STALL),
    .PC_REDIRECT_VALID (PC_REDIRECT_VALID),
    .PC_REDIRECT       (PC_REDIRECT),
    .STALL_CNT         (STALL_CNT),
    .FLUSH_CNT         (FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs, push expectation, compare at negedge, advance past posedge.
  task automatic step(input string name, input logic rst, input logic mp, input logic [31:0] pc,
                      input logic sc, input logic sd, input logic miss, input logic lu,
                      input logic e_stall, input logic e_flush, input logic e_rv, input logic full);
    exp_t e, o;
    RESET = rst; MISPREDICT = mp; REDIRECT_PC = pc; SYSCALL = sc;
    SYSCALL_DONE = sd; ICACHE_MISS = miss; LOAD_USE = lu;
    e.name = name; e.full = full; e.stall = e_stall; e.flush = e_flush; e.rv = e_rv;
    e.pc = exp_pc; e.sc = exp_sc; e.fc = exp_fc;
    sb.push_back(e);
    @(negedge CLK);
    o = sb.pop_front();
    checks++;
    if (IFID_STALL !== o.stall) begin
      errors++; $display("FAIL %s ifid_stall got %b want %b", o.name, IFID_STALL, o.stall);
    end
    checks++;
    if (IFID_FLUSH !== o.flush) begin
      errors++; $display("FAIL %s ifid_flush got %b want %b", o.name, IFID_FLUSH, o.flush);
    end
    checks++;
    if (PC_STALL !== o.stall) begin
      errors++; $display("FAIL %s pc_stall got %b want %b", o.name, PC_STALL, o.stall);
    end
    if (o.full) begin
      checks++;
      if (PC_REDIRECT_VALID !== o.rv) begin
        errors++; $display("FAIL %s redirect_valid got %b want %b", o.name, PC_REDIRECT_VALID, o.rv);
      end
      checks++;
      if (PC_REDIRECT !== o.pc) begin
        errors++; $display("FAIL %s pc_redirect got %h want %h", o.name, PC_REDIRECT, o.pc);
      end
      checks++;
      if (STALL_CNT !== o.sc) begin
        errors++; $display("FAIL %s stall_cnt got %0d want %0d", o.name, STALL_CNT, o.sc);
      end
      checks++;
      if (FLUSH_CNT !== o.fc) begin
        errors++; $display("FAIL %s flush_cnt got %0d want %0d", o.name, FLUSH_CNT, o.fc);
      end
    end
    @(posedge CLK);
    #1;
    if (rst) begin
      exp_pc = 32'd0; exp_sc = 32'd0; exp_fc = 32'd0;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      exp_sc = exp_sc + 32'(e_stall);
      exp_fc = exp_fc + 32'(e_flush);
`endif
    end
  endtask

  task automatic idle(input string name, input logic e_stall, input logic e_flush, input logic e_rv);
    step(name, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, e_stall, e_flush, e_rv, 1'b1);
  endtask

  task automatic test_reset();
    step("rst0", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst1", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("rst_idle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_flush();
    step("rmf_mp", 1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_pc = 32'h0000_1234;
    idle("rmf_fl", 1'b0, 1'b1, 1'b1);
    step("rmf_r0", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rmf_r1", 1'b1, 1'b1, 32'h5555_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("rmf_post", 1'b0, 1'b0, 1'b0);
    step("rmf_run", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mispredict();
    step("mp", 1'b0, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_pc = 32'h0040_0100;
    idle("mp_f1", 1'b0, 1'b1, 1'b1);
    idle("mp_f2", 1'b0, 1'b1, 1'b0);
    idle("mp_run", 1'b0, 1'b0, 1'b0);
    step("mp_lu", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    step("b2b_mp1", 1'b0, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_pc = 32'h0040_0100;
    step("b2b_mp2", 1'b0, 1'b1, 32'h0040_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_pc = 32'h0040_0200;
    // Syscall, done and load-use during a flush have no effect.
    step("b2b_f2", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle("b2b_f3", 1'b0, 1'b1, 1'b0);
    idle("b2b_run", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_syscall_miss();
    step("sc_done_run", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("sc", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle("sc_wait", 1'b1, 1'b0, 1'b0);
    step("sc_done", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("sc_miss1", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("sc_miss2", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle("sc_miss_fall", 1'b1, 1'b0, 1'b0);
    idle("sc_run", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_icache_miss();
    step("im_run", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("im_wait", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle("im_fall", 1'b1, 1'b0, 1'b0);
    idle("im_back", 1'b0, 1'b0, 1'b0);
    step("im_mp", 1'b0, 1'b1, 32'h0040_0500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_pc = 32'h0040_0500;
    idle("im_f1", 1'b0, 1'b1, 1'b1);
    step("im_f2_miss", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle("im_after_flush", 1'b1, 1'b0, 1'b0);
    idle("im_run2", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    step("pri_all", 1'b0, 1'b1, 32'h0040_0300, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_pc = 32'h0040_0300;
    idle("pri_f1", 1'b0, 1'b1, 1'b1);
    idle("pri_f2", 1'b0, 1'b1, 1'b0);
    idle("pri_run", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_counters();
    logic [31:0] want_sc, want_fc;
    step("cnt_rst", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step("cnt_lu", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("cnt_mp", 1'b0, 1'b1, 32'h0040_0400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_pc = 32'h0040_0400;
    idle("cnt_f1", 1'b0, 1'b1, 1'b1);
    idle("cnt_f2", 1'b0, 1'b1, 1'b0);
    idle("cnt_end", 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    want_sc = 32'd4; want_fc = 32'd2;
`else
    want_sc = 32'd0; want_fc = 32'd0;
`endif
    @(negedge CLK);
    checks++;
    if (STALL_CNT !== want_sc) begin
      errors++; $display("FAIL cnt_total stall_cnt got %0d want %0d", STALL_CNT, want_sc);
    end
    checks++;
    if (FLUSH_CNT !== want_fc) begin
      errors++; $display("FAIL cnt_total flush_cnt got %0d want %0d", FLUSH_CNT, want_fc);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; MISPREDICT = 1'b0; REDIRECT_PC = 32'd0; SYSCALL = 1'b0;
    SYSCALL_DONE = 1'b0; ICACHE_MISS = 1'b0; LOAD_USE = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_reset_mid_flush();
    test_mispredict();
    test_back_to_back();
    test_syscall_miss();
    test_icache_miss();
    test_priority();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
